bp_fe_pred_update_sched: RTL and testbench
==========================================

BP_FE_PRED_UPDATE_SCHED -- requirements
Module: bp_fe_pred_update_sched

Interface
REQ-001 Parameter idx_width_p, default 6, table index width (table depth = 2^idx_width_p).
REQ-002 Parameter data_width_p, default 16, update payload width.
REQ-003 Parameter fifo_els_p, default 2, attaboy queue depth (>=2).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 init_done_o  output  1  high once the table clear sweep completes.
REQ-007 redir_v_i  input  1  redirect update strobe; single cycle, no backpressure.
REQ-008 redir_idx_i / redir_data_i  input  idx_width_p / data_width_p  redirect update index/payload.
REQ-009 attaboy_v_i  input  1  attaboy update valid (ready/valid).
REQ-010 attaboy_ready_o  output  1  attaboy accept; transfer when attaboy_v_i & attaboy_ready_o.
REQ-011 attaboy_idx_i / attaboy_data_i  input  idx_width_p / data_width_p  attaboy index/payload.
REQ-012 w_v_o  output  1  table write request.
REQ-013 w_idx_o / w_data_o  output  idx_width_p / data_width_p  write index/payload.
REQ-014 w_force_o  output  1  high for init and redirect writes, low for attaboy writes.
REQ-015 w_yumi_i  input  1  table accepts write this cycle; legal only when w_v_o=1.
REQ-016 drop_count_o  output  8  saturating count of attaboy updates discarded by redirect flush.

Function
REQ-017 FSM states e_init, e_run; e_init entered on reset; e_run entered the cycle after the write to index 2^idx_width_p-1 is yumi'd.
REQ-018 e_init: w_v_o=1, w_force_o=1, w_data_o=0, w_idx_o=sweep counter starting at 0; counter advances by 1 on each w_yumi_i.
REQ-019 init_done_o=1 iff state is e_run.
REQ-020 In e_init, redir_v_i is ignored and attaboy_ready_o=0.
REQ-021 e_run: redirect captured into one-entry holding register on redir_v_i; holding register drives w_v_o from the following cycle.
REQ-022 New redir_v_i while the holding register is occupied overwrites it (latest wins); if w_yumi_i occurs in the same cycle, the old entry completes and the new one is loaded.
REQ-023 Write select priority: held redirect, then attaboy FIFO head; w_force_o=1 for redirect, 0 for attaboy.
REQ-024 attaboy_ready_o = (state e_run) & FIFO not full & ~redir_v_i; combinational in redir_v_i.
REQ-025 Enqueued attaboy is presented on w_v_o no earlier than the next cycle; FIFO head dequeues on w_yumi_i when the head is selected.
REQ-026 Simultaneous enqueue and dequeue with FIFO full is not allowed (ready low when full); with FIFO non-full both occur in the same cycle.
REQ-027 redir_v_i in e_run flushes all FIFO entries except a head yumi'd that same cycle (that write counts as completed).
REQ-028 drop_count_o increases by the number of flushed entries, saturating at 255, never wraps.
REQ-029 w_v_o=0 in e_run when holding register and FIFO are both empty; w_idx_o/w_data_o are don't-care then.
REQ-030 w_v_o, once asserted, holds with stable w_idx_o/w_data_o until w_yumi_i, except when superseded per REQ-022 or REQ-027.

Reset
REQ-031 reset_n_i low asynchronously: state=e_init, sweep counter=0, holding register and FIFO empty, drop_count_o=0.
REQ-032 During reset: init_done_o=0, attaboy_ready_o=0, w_v_o=0; w_v_o rises the first clock edge after reset_n_i deasserts.
REQ-033 Reset asserted mid-sweep or mid-run discards all pending updates and restarts the sweep from index 0.

Verification
REQ-034 idx_width_p=4, w_yumi_i held 1 after reset release -> 16 writes, indices 0..15, data 0, force=1; init_done_o=1 on the 17th cycle.
REQ-035 e_run, attaboy idx=3 accepted at cycle t, w_yumi_i=1 -> w_v_o=1, w_idx_o=3, w_force_o=0 at t+1; FIFO empty at t+2.
REQ-036 FIFO holds 2 attaboys, w_yumi_i=0, redir_v_i idx=7 -> attaboy_ready_o=0 that cycle; next cycle w_idx_o=7, w_force_o=1; drop_count_o=2.
REQ-037 Redirect idx=5 pending with w_yumi_i=0, redirect idx=9 arrives -> w_idx_o=9 next cycle; only one redirect write observed.
REQ-038 drop_count_o=254, redirect flushes 2 entries -> drop_count_o=255; further flush keeps 255.
REQ-039 reset_n_i pulsed low at sweep index 8 -> outputs clear immediately; sweep restarts at index 0, init_done_o=0 until complete.

Source files
------------

// File: rtl/bp_fe_pred_update_sched_if.sv
// Update-side bundle of the predictor table write scheduler: redirect strobe,
// attaboy ready/valid stream and the table write port.
interface bp_fe_pred_update_sched_if #(
  parameter int idx_width_p  = 6,
  parameter int data_width_p = 16
);
  logic                    redir_v_i;
  logic [idx_width_p-1:0]  redir_idx_i;
  logic [data_width_p-1:0] redir_data_i;

  logic                    attaboy_v_i;
  logic                    attaboy_ready_o;
  logic [idx_width_p-1:0]  attaboy_idx_i;
  logic [data_width_p-1:0] attaboy_data_i;

  logic                    w_v_o;
  logic [idx_width_p-1:0]  w_idx_o;
  logic [data_width_p-1:0] w_data_o;
  logic                    w_force_o;
  logic                    w_yumi_i;

  modport slave (
    input  redir_v_i, redir_idx_i, redir_data_i,
    input  attaboy_v_i, attaboy_idx_i, attaboy_data_i,
    output attaboy_ready_o,
    output w_v_o, w_idx_o, w_data_o, w_force_o,
    input  w_yumi_i
  );

  modport master (
    output redir_v_i, redir_idx_i, redir_data_i,
    output attaboy_v_i, attaboy_idx_i, attaboy_data_i,
    input  attaboy_ready_o,
    input  w_v_o, w_idx_o, w_data_o, w_force_o,
    output w_yumi_i
  );
endinterface

// File: rtl/bp_fe_pred_update_sched.sv
// Predictor table write scheduler: clears the table after reset, then merges
// forced redirect updates (one-entry, latest wins) with queued attaboy updates.
module bp_fe_pred_update_sched #(
  parameter int idx_width_p  = 6,
  parameter int data_width_p = 16,
  parameter int fifo_els_p   = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  output logic       init_done_o,
  output logic [7:0] drop_count_o,
  bp_fe_pred_update_sched_if.slave bus
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

  typedef enum logic {e_init, e_run} state_e;

  state_e state_r, state_n;
  logic   out_en_r;

  logic [idx_width_p-1:0]  sweep_r, sweep_n;
  logic                    hold_v_r, hold_v_n;
  logic [idx_width_p-1:0]  hold_idx_r, hold_idx_n;
  logic [data_width_p-1:0] hold_data_r, hold_data_n;

  logic [idx_width_p-1:0]  fifo_idx_r  [fifo_els_p];
  logic [data_width_p-1:0] fifo_data_r [fifo_els_p];
  logic [ptr_w_lp-1:0]     rd_ptr_r, rd_ptr_n, wr_ptr_r, wr_ptr_n;
  logic [cnt_w_lp-1:0]     cnt_r, cnt_n, flushed;
  logic [7:0]              drop_r, drop_n;
  logic [8:0]              drop_sum;

  logic fifo_empty, fifo_full, fifo_enq, fifo_deq;
  logic ready, w_v, w_force;
  logic [idx_width_p-1:0]  w_idx;
  logic [data_width_p-1:0] w_data;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (cnt_r == '0);
  assign fifo_full  = (cnt_r == cnt_w_lp'(fifo_els_p));

  always_comb begin
    state_n     = state_r;
    sweep_n     = sweep_r;
    hold_v_n    = hold_v_r;
    hold_idx_n  = hold_idx_r;
    hold_data_n = hold_data_r;
    rd_ptr_n    = rd_ptr_r;
    wr_ptr_n    = wr_ptr_r;
    cnt_n       = cnt_r;
    drop_n      = drop_r;
    flushed     = '0;
    drop_sum    = '0;
    fifo_enq    = 1'b0;
    fifo_deq    = 1'b0;
    ready       = 1'b0;
    w_v         = 1'b0;
    w_force     = 1'b0;
    w_idx       = fifo_idx_r[rd_ptr_r];
    w_data      = fifo_data_r[rd_ptr_r];

    case (state_r)
      e_init: begin
        // out_en_r keeps the write request low until the first edge after reset
        w_v     = out_en_r;
        w_force = 1'b1;
        w_idx   = sweep_r;
        w_data  = '0;
        if (out_en_r && bus.w_yumi_i) begin
          sweep_n = sweep_r + 1'b1;
          if (sweep_r == '1) state_n = e_run;
        end
      end

      e_run: begin
        ready = ~fifo_full & ~bus.redir_v_i;
        w_v   = hold_v_r | ~fifo_empty;
        if (hold_v_r) begin
          w_force = 1'b1;
          w_idx   = hold_idx_r;
          w_data  = hold_data_r;
        end
        fifo_deq = bus.w_yumi_i & ~hold_v_r & ~fifo_empty;
        fifo_enq = bus.attaboy_v_i & ready;

        if (bus.redir_v_i) begin
          hold_v_n    = 1'b1;
          hold_idx_n  = bus.redir_idx_i;
          hold_data_n = bus.redir_data_i;
          // a head written this same cycle completed, so it is not a drop
          flushed  = cnt_r - cnt_w_lp'(fifo_deq);
          drop_sum = {1'b0, drop_r} + 9'(flushed);
          drop_n   = drop_sum[8] ? 8'hff : drop_sum[7:0];
          rd_ptr_n = wr_ptr_r;
          cnt_n    = '0;
        end else begin
          if (bus.w_yumi_i && hold_v_r) hold_v_n = 1'b0;
          if (fifo_deq) rd_ptr_n = ptr_inc(rd_ptr_r);
          if (fifo_enq) wr_ptr_n = ptr_inc(wr_ptr_r);
          cnt_n = cnt_r + cnt_w_lp'(fifo_enq) - cnt_w_lp'(fifo_deq);
        end
      end

      default: state_n = e_init;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_init;
      out_en_r    <= 1'b0;
      sweep_r     <= '0;
      hold_v_r    <= 1'b0;
      hold_idx_r  <= '0;
      hold_data_r <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      cnt_r       <= '0;
      drop_r      <= '0;
    end else begin
      state_r     <= state_n;
      out_en_r    <= 1'b1;
      sweep_r     <= sweep_n;
      hold_v_r    <= hold_v_n;
      hold_idx_r  <= hold_idx_n;
      hold_data_r <= hold_data_n;
      rd_ptr_r    <= rd_ptr_n;
      wr_ptr_r    <= wr_ptr_n;
      cnt_r       <= cnt_n;
      drop_r      <= drop_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_enq) begin
      fifo_idx_r[wr_ptr_r]  <= bus.attaboy_idx_i;
      fifo_data_r[wr_ptr_r] <= bus.attaboy_data_i;
    end
  end

  assign init_done_o         = (state_r == e_run);
  assign drop_count_o        = drop_r;
  assign bus.attaboy_ready_o = ready;
  assign bus.w_v_o           = w_v;
  assign bus.w_idx_o         = w_idx;
  assign bus.w_data_o        = w_data;
  assign bus.w_force_o       = w_force;

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
// Directed bench for bp_fe_pred_update_sched: init sweep, run-mode vector table,
// drop counter saturation and reset during run and mid-sweep.
module tb_bp_fe_pred_update_sched;
  localparam int iw = 4;
  localparam int dw = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_done;
  logic [7:0] drop_count;

  int tests = 0;
  int fails = 0;

  bp_fe_pred_update_sched_if #(.idx_width_p(iw), .data_width_p(dw)) bus ();

  bp_fe_pred_update_sched #(.idx_width_p(iw), .data_width_p(dw), .fifo_els_p(2)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .init_done_o (init_done),
    .drop_count_o(drop_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [iw-1:0] ri;
    logic [dw-1:0] rd;
    logic          av;
    logic [iw-1:0] ai;
    logic [dw-1:0] ad;
    logic          y;
    logic          rdy;
    logic          wv;
    logic [iw-1:0] wi;
    logic          wf;
    logic [dw-1:0] wd;
    logic [7:0]    drop;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic rv, input logic [iw-1:0] ri, input logic [dw-1:0] rd,
                              input logic av, input logic [iw-1:0] ai, input logic [dw-1:0] ad,
                              input logic y, input logic rdy, input logic wv, input logic [iw-1:0] wi,
                              input logic wf, input logic [dw-1:0] wd, input logic [7:0] drop);
    vec_t v;
    v.rv = rv; v.ri = ri; v.rd = rd; v.av = av; v.ai = ai; v.ad = ad; v.y = y;
    v.rdy = rdy; v.wv = wv; v.wi = wi; v.wf = wf; v.wd = wd; v.drop = drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then wait for the falling edge to sample.
  task automatic apply(input logic rv, input logic [iw-1:0] ri, input logic [dw-1:0] rd,
                       input logic av, input logic [iw-1:0] ai, input logic [dw-1:0] ad,
                       input logic y);
    @(posedge clk);
    #1;
    bus.redir_v_i = rv; bus.redir_idx_i = ri; bus.redir_data_i = rd;
    bus.attaboy_v_i = av; bus.attaboy_idx_i = ai; bus.attaboy_data_i = ad;
    bus.w_yumi_i = y;
    @(negedge clk);
  endtask

  task automatic sweep_check(input string tag);
    int  n = 0;
    bit  done = 1'b0;
    bus.w_yumi_i = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (init_done) done = 1'b1;
      else if (bus.w_v_o) begin
        check($sformatf("%s_idx%0d", tag, n), 32'(bus.w_idx_o), 32'(n));
        check($sformatf("%s_frc%0d", tag, n), 32'(bus.w_force_o), 32'd1);
        check($sformatf("%s_dat%0d", tag, n), 32'(bus.w_data_o), 32'd0);
        n++;
      end
    end
    bus.w_yumi_i = 1'b0;
    check({tag, "_writes"}, 32'(n), 32'd16);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic flush_round(input int n);
    for (int k = 0; k < n; k++) apply(0, 0, 0, 1, iw'(k), dw'(k), 0);
    apply(1, 15, 16'hffff, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    vec_t v;
    bit   hit;
    bus.redir_v_i = 0; bus.redir_idx_i = 0; bus.redir_data_i = 0;
    bus.attaboy_v_i = 0; bus.attaboy_idx_i = 0; bus.attaboy_data_i = 0;
    bus.w_yumi_i = 0;

    //            rv ri rd         av ai ad         y  rdy wv wi wf wd         drop
    vecs[0]  = mk(0, 0, 0,         0, 0, 0,         0, 1, 0, 0, 0, 0,         0);
    vecs[1]  = mk(0, 0, 0,         1, 3, 16'h0a03,  0, 1, 0, 0, 0, 0,         0);
    vecs[2]  = mk(0, 0, 0,         0, 0, 0,         1, 1, 1, 3, 0, 16'h0a03,  0);
    vecs[3]  = mk(0, 0, 0,         0, 0, 0,         0, 1, 0, 0, 0, 0,         0);
    vecs[4]  = mk(0, 0, 0,         1, 1, 16'h0101,  0, 1, 0, 0, 0, 0,         0);
    vecs[5]  = mk(0, 0, 0,         1, 2, 16'h0202,  0, 1, 1, 1, 0, 16'h0101,  0);
    vecs[6]  = mk(0, 0, 0,         1, 4, 16'h0404,  0, 0, 1, 1, 0, 16'h0101,  0);
    vecs[7]  = mk(1, 7, 16'h0707,  0, 0, 0,         0, 0, 1, 1, 0, 16'h0101,  0);
    vecs[8]  = mk(0, 0, 0,         0, 0, 0,         0, 1, 1, 7, 1, 16'h0707,  2);
    vecs[9]  = mk(0, 0, 0,         1, 6, 16'h0606,  1, 1, 1, 7, 1, 16'h0707,  2);
    vecs[10] = mk(0, 0, 0,         0, 0, 0,         0, 1, 1, 6, 0, 16'h0606,  2);
    vecs[11] = mk(0, 0, 0,         1, 8, 16'h0808,  1, 1, 1, 6, 0, 16'h0606,  2);
    vecs[12] = mk(1, 5, 16'h0505,  0, 0, 0,         1, 0, 1, 8, 0, 16'h0808,  2);
    vecs[13] = mk(1, 9, 16'h0909,  0, 0, 0,         0, 0, 1, 5, 1, 16'h0505,  2);
    vecs[14] = mk(0, 0, 0,         0, 0, 0,         1, 1, 1, 9, 1, 16'h0909,  2);
    vecs[15] = mk(0, 0, 0,         0, 0, 0,         0, 1, 0, 0, 0, 0,         2);
    vecs[16] = mk(1, 10, 16'h0a0a, 0, 0, 0,         0, 0, 0, 0, 0, 0,         2);
    vecs[17] = mk(1, 11, 16'h0b0b, 0, 0, 0,         1, 0, 1, 10, 1, 16'h0a0a, 2);
    vecs[18] = mk(0, 0, 0,         0, 0, 0,         1, 1, 1, 11, 1, 16'h0b0b, 2);
    vecs[19] = mk(0, 0, 0,         0, 0, 0,         0, 1, 0, 0, 0, 0,         2);
    vecs[20] = mk(0, 0, 0,         1, 12, 16'h0c0c, 0, 1, 0, 0, 0, 0,         2);
    vecs[21] = mk(1, 13, 16'h0d0d, 0, 0, 0,         0, 0, 1, 12, 0, 16'h0c0c, 2);
    vecs[22] = mk(0, 0, 0,         1, 14, 16'h0e0e, 0, 1, 1, 13, 1, 16'h0d0d, 3);
    vecs[23] = mk(0, 0, 0,         0, 0, 0,         1, 1, 1, 13, 1, 16'h0d0d, 3);
    vecs[24] = mk(0, 0, 0,         0, 0, 0,         1, 1, 1, 14, 0, 16'h0e0e, 3);
    vecs[25] = mk(0, 0, 0,         0, 0, 0,         0, 1, 0, 0, 0, 0,         3);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_w_v", 32'(bus.w_v_o), 32'd0);
    check("rst_ready", 32'(bus.attaboy_ready_o), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.w_yumi_i = 1'b1;
    @(negedge clk);
    check("rel_w_v_low", 32'(bus.w_v_o), 32'd0);
    sweep_check("sweep0");

    for (int i = 0; i < 26; i++) begin
      v = vecs[i];
      apply(v.rv, v.ri, v.rd, v.av, v.ai, v.ad, v.y);
      check($sformatf("v%0d_ready", i), 32'(bus.attaboy_ready_o), 32'(v.rdy));
      check($sformatf("v%0d_w_v", i), 32'(bus.w_v_o), 32'(v.wv));
      check($sformatf("v%0d_drop", i), 32'(drop_count), 32'(v.drop));
      if (v.wv) begin
        check($sformatf("v%0d_w_idx", i), 32'(bus.w_idx_o), 32'(v.wi));
        check($sformatf("v%0d_w_force", i), 32'(bus.w_force_o), 32'(v.wf));
        check($sformatf("v%0d_w_data", i), 32'(bus.w_data_o), 32'(v.wd));
      end
    end

    // drop counter: 3 -> 4 -> 254 -> 255 -> 255
    flush_round(1);
    check("drop_4", 32'(drop_count), 32'd4);
    for (int r = 0; r < 125; r++) flush_round(2);
    check("drop_254", 32'(drop_count), 32'd254);
    flush_round(2);
    check("drop_sat", 32'(drop_count), 32'd255);
    flush_round(2);
    check("drop_hold", 32'(drop_count), 32'd255);

    // reset during run with a held redirect and a queued attaboy
    apply(1, 3, 16'h3333, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 2, 16'h2222, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.attaboy_v_i = 1'b0;
    #1;
    check("runrst_w_v", 32'(bus.w_v_o), 32'd0);
    check("runrst_done", 32'(init_done), 32'd0);
    check("runrst_ready", 32'(bus.attaboy_ready_o), 32'd0);
    check("runrst_drop", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.w_yumi_i = 1'b1;
    @(negedge clk);
    check("runrst_rel_w_v", 32'(bus.w_v_o), 32'd0);

    // reset pulse at sweep index 8
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.w_v_o && bus.w_idx_o == 4'd8) hit = 1'b1;
    end
    check("mid_sweep_reach8", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_w_v", 32'(bus.w_v_o), 32'd0);
    check("midrst_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    sweep_check("sweep1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
